// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal tx FIFO: frames go out LSB first with optional parity
// and 1/2 stop bits; parity/stop config is latched per frame when the word is popped.
module uart_tx_fifo #(
    parameter int unsigned DATA_WD      = 8,
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        din_valid,
    input  logic [DATA_WD-1:0]          din,
    output logic                        din_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned TickW = $clog2(OVERSAMPLING);
    localparam int unsigned BitW  = $clog2(DATA_WD);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLING - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WD - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_WD-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               push, pop, fifo_empty;
    logic [DATA_WD-1:0] rd_data;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WD-1:0] shift_q, shift_d;
    logic               par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic               tx_q, tx_d, tx_done_q, tx_done_d;
    logic               bit_end, start_frame;

    // FIFO bookkeeping; din_ready looks only at the registered count.
    always_comb begin
        din_ready  = (count_q != CntFull);
        fifo_empty = (count_q == '0);
        push       = din_valid && din_ready;
        rd_data    = mem_q[rd_ptr_q];
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        tx_done_d   = 1'b0;
        pop         = 1'b0;
        start_frame = 1'b0;
        bit_end     = tick && (tick_cnt_q == TickLast);

        if (tick && state_q != StIdle) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle:   start_frame = !fifo_empty;
            StStart:  if (bit_end) state_d = StData;
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: if (bit_end) state_d = StStop;
            StStop: begin
                // bit_cnt doubles as the stop-bit counter for the 2-stop case.
                if (bit_end) begin
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = BitW'(1);
                    end else begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default:  state_d = StIdle;
        endcase

        if (start_frame) begin
            pop        = 1'b1;
            state_d    = StStart;
            shift_d    = rd_data;
            par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_d  = (^rd_data) ^ (cfg_parity == 2'b01);
            stop2_d    = cfg_stop2;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end

        // tx is registered from the next state so the line changes on the same edge.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign tx_busy    = (state_q != StIdle);
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes record the expected frame in a queue; a monitor
// decodes the tx line, checks each bit's value and width, and the tx_done timing.
module tb_uart_tx_fifo;
    localparam int DW = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b1;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_ready, tx, tx_busy, tx_done;
    logic [3:0]    fifo_count;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic mon_en = 1'b1;
    logic mon_busy = 1'b0;

    typedef struct {
        logic [12:0] bits;
        int          n;
    } frame_t;
    frame_t exp_q[$];

    uart_tx_fifo #(.DATA_WD(DW), .OVERSAMPLING(OS), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .fifo_count(fifo_count), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Returns #1 after the edge that accepted the word.
    task automatic push_raw(input logic [DW-1:0] d);
        int w = 0;
        @(negedge clk);
        din = d;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            total++;
            bad++;
            $display("FAIL push_timeout: din_ready stuck low, word %0h", d);
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    // Line values in order: start, data LSB first, optional parity (hand-given), stop(s).
    task automatic push_word(input logic [DW-1:0] d, input logic has_par, input logic pbit,
                             input logic s2);
        frame_t f;
        int     idx;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
        idx = 1 + DW;
        if (has_par) begin
            f.bits[idx] = pbit;
            idx++;
        end
        f.bits[idx] = 1'b1;
        idx++;
        if (s2) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.n = idx;
        exp_q.push_back(f);
        push_raw(d);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || mon_busy || tx_busy !== 1'b0) && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 6000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d frames still expected", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        frame_t      e;
        logic [12:0] got;
        logic        stable;
        forever begin
            @(negedge clk);
            while (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: start bit seen, nothing queued");
                    e.bits = '1;
                    e.n = 10;
                end else begin
                    e = exp_q.pop_front();
                end
                got = '0;
                stable = 1'b1;
                for (int k = 0; k < e.n; k++) begin
                    for (int s = 0; s < OS; s++) begin
                        if (k != 0 || s != 0) @(negedge clk);
                        if (s == 0) got[k] = tx;
                        else if (tx !== got[k]) stable = 1'b0;
                        if (tx_busy !== 1'b1) stable = 1'b0;
                        if ((k != 0 || s != 0) && tx_done !== 1'b0) stable = 1'b0;
                    end
                end
                @(negedge clk);
                check("frame_bits", {stable, got}, {1'b1, e.bits});
                check("done_timing", tx_done, 1);
                mon_busy = 1'b0;
            end
        end
    end

    logic [DW-1:0] words [10];
    int            lows;
    int            d0;

    initial begin
        words = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h18, 8'h5A, 8'hA5, 8'h66, 8'h99};

        // Reset state and quiet idle line
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", din_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("idle_line", lows, 0);

        // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
        push_word(8'hA5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_start_tx", tx, 1);
        check("pre_start_count", fifo_count, 1);
        @(negedge clk);
        check("start_tx", tx, 0);
        check("start_busy", tx_busy, 1);
        check("post_pop_count", fifo_count, 0);
        wait_drain();
        check("done_cnt_8n1", done_cnt, 1);

        // Parity: 0x07 has three ones -> odd bit 0, even bit 1; then two stop bits
        cfg_parity = 2'b01;
        push_word(8'h07, 1'b1, 1'b0, 1'b0);
        wait_drain();
        cfg_parity = 2'b10;
        push_word(8'h07, 1'b1, 1'b1, 1'b0);
        wait_drain();
        cfg_parity = 2'b11;
        cfg_stop2 = 1'b1;
        push_word(8'h55, 1'b0, 1'b0, 1'b1);
        wait_drain();
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        check("done_cnt_par", done_cnt, 4);

        // Fill the FIFO behind a running frame
        for (int i = 0; i < 9; i++) begin
            push_word(words[i], 1'b0, 1'b0, 1'b0);
            if (i == 4) check("count_mid", fifo_count, 4);
        end
        check("count_full", fifo_count, 8);
        check("ready_full", din_ready, 0);
        push_word(words[9], 1'b0, 1'b0, 1'b0);
        check("count_refill", fifo_count, 8);
        wait_drain();
        check("done_cnt_burst", done_cnt, 14);

        // Mid-frame config change: 0x0F none, then 0x0F odd (four ones -> bit 1)
        push_word(8'h0F, 1'b0, 1'b0, 1'b0);
        push_word(8'h0F, 1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        cfg_parity = 2'b10;
        repeat (40) @(negedge clk);
        cfg_parity = 2'b01;
        wait_drain();
        cfg_parity = 2'b00;
        check("done_cnt_cfg", done_cnt, 16);

        // Reset in DATA bit 3 of 0xF0 (line low there) with three words queued
        mon_en = 1'b0;
        d0 = done_cnt;
        push_raw(8'hF0);
        push_raw(8'h11);
        push_raw(8'h22);
        push_raw(8'h33);
        repeat (67) @(negedge clk);
        check("pre_rst_bit3", tx, 0);
        check("pre_rst_count", fifo_count, 3);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_count", fifo_count, 0);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", din_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("post_abort_idle", lows, 0);
        check("abort_no_done", done_cnt, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
